// File: rtl/jtframe_sdram_pkg.sv
// Shared definitions for the jtframe SDRAM bank arbiters: FSM encoding,
// SDRAM word-address width and client-to-word address conversion.
package jtframe_sdram_pkg;

    localparam int SDRAM_AW = 22;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_FILL2 = 2'd3;

    // Client addresses count DW-sized units; the SDRAM counts 16-bit words.
    function automatic logic [SDRAM_AW-1:0] word_addr(input logic [31:0] addr, input int dw);
        logic [31:0] w;
        case (dw)
            8:       w = addr >> 1;
            32:      w = addr << 1;
            default: w = addr;
        endcase
        return SDRAM_AW'(w);
    endfunction

endpackage

// File: rtl/jtframe_nslot_arb.sv
// SLOTS-wide request arbiter: fixed (lowest index) or round-robin starting
// after the last granted slot.
module jtframe_nslot_arb #(
    parameter int SLOTS  = 4,
    parameter int RROBIN = 0,
    parameter int IW     = 2
) (
    input  logic [SLOTS-1:0] pend_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [SLOTS-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    always_comb begin
        logic found;
        int   j;
        gnt_o = '0;
        idx_o = '0;
        any_o = |pend_i;
        found = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            j = (RROBIN != 0) ? (int'(ptr_i) + 1 + k) % SLOTS : k;
            if (!found && pend_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/jtframe_rom_nslots.sv
// N-slot read-only SDRAM bank arbiter with a one-entry tag cache per slot.
// One bank transaction is outstanding at a time.
module jtframe_rom_nslots
    import jtframe_sdram_pkg::*;
#(
    parameter int                        SLOTS  = 4,
    parameter int                        DW     = 16,
    parameter int                        AW     = 18,
    parameter logic [SLOTS*SDRAM_AW-1:0] OFFSET = '0,
    parameter int                        RROBIN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    input  logic [SLOTS-1:0]      slot_clr,
    output logic [SLOTS*DW-1:0]   slot_dout,
    output logic [SLOTS-1:0]      slot_ok,
    output logic [SDRAM_AW-1:0]   sdram_addr,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    input  logic                  data_dst,
    input  logic                  data_rdy,
    input  logic [15:0]           data_read
);

    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [SLOTS-1:0]    valid_q, hit, pend, gnt;
    logic [AW-1:0]       tag_q  [SLOTS];
    logic [DW-1:0]       data_q [SLOTS];
    logic [1:0]          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d, ptr_q, ptr_d, gidx;
    logic [AW-1:0]       ltag_q, ltag_d, sel_addr;
    logic [SDRAM_AW-1:0] addr_q, addr_d, sel_off;
    logic                req_q, req_d, kill_q, kill_d, any_pend, wr_en;
    logic [15:0]         lo_q, lo_d;
    logic [DW-1:0]       wr_data;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            hit[i]  = slot_cs[i] & valid_q[i] & (tag_q[i] == slot_addr[i*AW +: AW]) & ~slot_clr[i];
            pend[i] = slot_cs[i] & ~hit[i] & ~slot_clr[i];
        end
    end

    assign slot_ok    = hit;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

    jtframe_nslot_arb #(.SLOTS(SLOTS), .RROBIN(RROBIN), .IW(IW)) u_arb (
        .pend_i (pend),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (gidx),
        .any_o  (any_pend)
    );

    always_comb begin
        sel_addr = '0;
        sel_off  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (gnt[i]) begin
                sel_addr |= slot_addr[i*AW +: AW];
                sel_off  |= OFFSET[i*SDRAM_AW +: SDRAM_AW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        ltag_d  = ltag_q;
        addr_d  = addr_q;
        req_d   = req_q;
        lo_d    = lo_q;
        kill_d  = kill_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: if (any_pend) begin
                idx_d   = gidx;
                ltag_d  = sel_addr;
                addr_d  = sel_off + word_addr(32'(sel_addr), DW);
                req_d   = 1'b1;
                kill_d  = 1'b0;
                state_d = ST_REQ;
                if (RROBIN != 0) ptr_d = gidx;
            end
            ST_REQ: if (sdram_ack) begin
                req_d   = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: if (data_dst) begin
                if (DW == 32) begin
                    lo_d    = data_read;
                    state_d = ST_FILL2;
                end else begin
                    wr_en   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FILL2: if (data_rdy) begin
                wr_en   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A clear seen at any point of the fill must keep the entry invalid.
        if (state_q != ST_IDLE && slot_clr[idx_q]) kill_d = 1'b1;
    end

    always_comb begin
        if (DW == 32)     wr_data = DW'({data_read, lo_q});
        else if (DW == 8) wr_data = DW'(ltag_q[0] ? data_read[15:8] : data_read[7:0]);
        else              wr_data = DW'(data_read);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ptr_q   <= IW'(SLOTS - 1);
            ltag_q  <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            lo_q    <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            ltag_q  <= ltag_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            lo_q    <= lo_d;
            kill_q  <= kill_d;
        end
    end

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end else begin
                if (wr_en && idx_q == IW'(i)) begin
                    tag_q[i]  <= ltag_q;
                    data_q[i] <= wr_data;
                end
                if (slot_clr[i])                    valid_q[i] <= 1'b0;
                else if (wr_en && idx_q == IW'(i))  valid_q[i] <= ~kill_q;
            end
        end
        assign slot_dout[i*DW +: DW] = data_q[i];
    end

endmodule

// File: doc/jtframe_rom_nslots.md
Name: jtframe_rom_nslots

Overview:
Parametrised N-slot read-only arbiter placed between game-side ROM clients and one SDRAM bank port of the jtframe SDRAM controller. It generalises the fixed 2-slot and 3-slot ROM arbiters used per bank in game SDRAM wrappers. Slot count, data width, address width and per-slot base offsets are all parametrised. Priority mode is selectable: fixed or round-robin. Each slot has a one-entry tag cache.

Parameters:
SLOTS, 4, number of client slots (1..8)
DW, 16, client data width for every slot: 8, 16 or 32
AW, 18, client address width, in DW-sized units
OFFSET, {SLOTS{22'h0}}, packed SLOTS*22 vector of per-slot SDRAM word offsets; slot i uses bits [i*22+:22]
RROBIN, 0, priority mode: 0 = fixed priority (lowest index wins); 1 = round-robin

Ports:
clk         in   1          system clock
rst_n       in   1          reset; synchronous, active-low
slot_cs     in   SLOTS      per-slot request
slot_addr   in   SLOTS*AW   packed per-slot address
slot_clr    in   SLOTS      per-slot cache invalidate
slot_dout   out  SLOTS*DW   packed per-slot data
slot_ok     out  SLOTS      per-slot data valid
sdram_addr  out  22         SDRAM word address
sdram_req   out  1          read request to controller
sdram_ack   in   1          controller accepted request
data_dst    in   1          first 16-bit word present on data_read
data_rdy    in   1          last word of the burst present
data_read   in   16         SDRAM read data

Behaviour:
- Reset (rst_n=0 at a clk edge): all cache valid bits = 0, tags = 0, slot_dout = 0, sdram_req = 0, sdram_addr = 0, FSM = IDLE, round-robin pointer = SLOTS-1. Reset mid-transaction aborts it and returns to IDLE; any pending data is discarded.
- Hit: slot_ok[i] = slot_cs[i] & valid[i] & (tag[i]==slot_addr[i]) & ~slot_clr[i]. This is combinational, so a hit has zero latency. slot_dout[i] is a register that holds the cached data.
- Pending: pend[i] = slot_cs[i] & ~hit[i] & ~slot_clr[i].
- SDRAM address conversion: DW=8 → offset + (addr>>1); DW=16 → offset + addr; DW=32 → offset + (addr<<1). All sums are 22-bit; overflow wraps modulo 2^22.
- FSM states:
  - IDLE: if any pend, select a winner, latch its index, address and tag, raise sdram_req, go to REQ.
    - Fixed mode: lowest pending index wins.
    - Round-robin mode: search starts at pointer+1, modulo SLOTS; the pointer updates to the winner on grant.
  - REQ: sdram_req and sdram_addr stay stable until sdram_ack. On ack, drop sdram_req the next cycle and go to WAIT.
  - WAIT: on data_dst, capture the word.
    - DW=16: data = data_read.
    - DW=8: data = tag[0] ? data_read[15:8] : data_read[7:0].
    - DW=32: low half = data_read; go to FILL2.
    - DW=8 and DW=16: write the cache, go to IDLE.
  - FILL2 (DW=32 only): the next data_rdy cycle provides the high half; write the cache, go to IDLE.
- Cache write: data, tag and valid=1 for the latched slot. The data is available as a hit the following cycle. Only one bank transaction is outstanding at a time.
- slot_cs dropping mid-transaction: the transaction completes and the cache is written. slot_ok stays low while cs is low.
- slot_addr changing mid-transaction: the cache is filled with the latched tag. No false hit. The new address issues a fresh request after returning to IDLE.
- slot_clr[i]: clears valid[i] on the same edge. If it is asserted while slot i is being filled, the fill completes but valid[i] remains 0. clr has priority over a simultaneous cache write.
- Unused slots (cs tied 0) never generate requests.

Decomposition:
- Shared package jtframe_sdram_pkg holds:
  - the FSM state encoding (IDLE, REQ, WAIT, FILL2)
  - a 22-bit SDRAM address width constant
  - a function that converts a client address to a word address from DW
- One sub-module, jtframe_nslot_arb: the SLOTS-wide fixed/round-robin arbiter (pend, pointer in; one-hot grant and index out).
- Per-slot caches are generated inline.

Test Plan:
1. DW=16, SLOTS=2, OFFSET={22'h10_0000,22'h0}: slot1 cs, addr 18'h0005 → sdram_addr=22'h10_0005. On data_dst with data_read=16'hBEEF: slot1_dout=16'hBEEF and slot_ok[1]=1 the next cycle. Repeat of the same addr → ok in 0 cycles with no sdram_req.
2. DW=32: addr 0x10 → sdram_addr=0x20. Supply 16'h1234 on dst, then 16'h5678 on rdy → dout=32'h5678_1234.
3. DW=8: addr 0x3 → sdram_addr=0x1. data_read=16'hA55A → dout=8'hA5.
4. RROBIN=1, SLOTS=4, all four slots pending with misses → grants in order 0,1,2,3. With RROBIN=0 and slot0 continuously missing at a new address each time, slot0 always wins.
5. Assert slot_clr[0] during slot0's WAIT → fill completes, the following request at the same addr misses and re-requests. Drop cs mid-REQ → the transaction completes and ok stays 0.
6. Pull rst_n low during FILL2 → next cycle sdram_req=0, all slot_ok=0, all dout=0, FSM in IDLE.
